// File: rtl/mul8_dot_acc.sv
`timescale 1ns/1ps
// mul8_dot_acc: streaming dot-product accumulator for an external 8x8 multiplier.
// Operand pairs accepted on IN_* are registered onto MUL_A/MUL_B. The product
// returned on MUL_O is summed with unsigned saturation over a LAST-terminated
// vector. The sum and count are then offered on the OUT_* handshake.
//
// Ports:
//   CLK, RST_N                      clock (rising edge), async active-low reset
//   IN_VALID/IN_READY               operand pair handshake (IN_READY from state only)
//   IN_A, IN_B, IN_LAST             unsigned operands and end-of-vector marker
//   MUL_A, MUL_B                    registered operands to the multiplier
//   MUL_O                           combinational product from the multiplier
//   OUT_VALID/OUT_READY             result handshake
//   OUT_SUM, OUT_CNT, OUT_OVF       saturated sum, product count, sticky saturation flag
//   OUT_ERR                         accumulated |exact - MUL_O| (0 unless error monitor built)
//
// Optional feature: define MUL8_DOT_ACC_ERR_MON_EN to build the exact-product error monitor.
module mul8_dot_acc #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_A,
  input  logic [7:0]       IN_B,
  input  logic             IN_LAST,
  output logic [7:0]       MUL_A,
  output logic [7:0]       MUL_B,
  input  logic [15:0]      MUL_O,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ACC_W-1:0] OUT_SUM,
  output logic [CNT_W-1:0] OUT_CNT,
  output logic             OUT_OVF,
  output logic [ACC_W-1:0] OUT_ERR
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e           state_q;
  logic             s1v_q;
  logic [7:0]       mul_a_q;
  logic [7:0]       mul_b_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             out_valid_q;
  logic             acc_sat;
  logic [SUM_W-1:0] acc_sum;
  logic             accept;
  logic             clr;

  assign IN_READY = (state_q == ST_ACC);
  assign accept   = IN_VALID && (state_q == ST_ACC);
  // Result handshake; also clears the accumulators for the next vector.
  assign clr      = (state_q == ST_HOLD) && OUT_READY;

  // Next accumulator and counter values, both saturating.
  always_comb begin
    acc_sum = {1'b0, acc_q} + SUM_W'(MUL_O);
    acc_sat = acc_sum[ACC_W];
    acc_d   = acc_sat ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Control FSM, operand stage and accumulate stage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_ACC;
      s1v_q       <= 1'b0;
      mul_a_q     <= 8'd0;
      mul_b_q     <= 8'd0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1v_q <= accept;
      if (accept) begin
        mul_a_q <= IN_A;
        mul_b_q <= IN_B;
      end

      case (state_q)
        ST_ACC: begin
          if (accept && IN_LAST) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // This edge performs the final accumulation.
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
        end
        ST_HOLD: begin
          if (OUT_READY) begin
            state_q     <= ST_ACC;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          out_valid_q <= 1'b0;
        end
      endcase

      // S1V is never set in HOLD, so clear and accumulate cannot collide.
      if (clr) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (s1v_q) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        if (acc_sat) ovf_q <= 1'b1;
      end
    end
  end

  assign MUL_A     = mul_a_q;
  assign MUL_B     = mul_b_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_SUM   = acc_q;
  assign OUT_CNT   = cnt_q;
  assign OUT_OVF   = ovf_q;

`ifdef MUL8_DOT_ACC_ERR_MON_EN
  logic [15:0]      exact_c;
  logic [15:0]      diff_c;
  logic [SUM_W-1:0] err_sum;
  logic [ACC_W-1:0] err_q;
  logic [ACC_W-1:0] err_d;

  // Absolute deviation of the returned product from the exact product.
  always_comb begin
    exact_c = 16'(mul_a_q) * 16'(mul_b_q);
    diff_c  = (exact_c >= MUL_O) ? (exact_c - MUL_O) : (MUL_O - exact_c);
    err_sum = {1'b0, err_q} + SUM_W'(diff_c);
    err_d   = err_sum[ACC_W] ? {ACC_W{1'b1}} : err_sum[ACC_W-1:0];
  end

  // Error accumulator, cleared together with the sum.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= '0;
    end else if (clr) begin
      err_q <= '0;
    end else if (s1v_q) begin
      err_q <= err_d;
    end
  end

  assign OUT_ERR = err_q;
`else
  assign OUT_ERR = '0;
`endif

endmodule

// File: tb/tb_mul8_dot_acc.sv
`timescale 1ns/1ps
// Bench for mul8_dot_acc: a 24-bit and a 16-bit accumulator instance share one stimulus.
module tb_mul8_dot_acc;

  localparam int unsigned ACC_W   = 24;
  localparam int unsigned ACC16_W = 16;
  localparam int unsigned CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, out_ready;
  logic [7:0] in_a, in_b;
  logic in_ready, out_valid, in_ready16, out_valid16;
  logic [7:0] mul_a, mul_b, mul_a16, mul_b16;
  logic [15:0] mul_o, mul_o16;
  logic [ACC_W-1:0] out_sum, out_err;
  logic [ACC16_W-1:0] out_sum16, out_err16;
  logic [CNT_W-1:0] out_cnt, out_cnt16;
  logic out_ovf, out_ovf16;

  int mode;
  int total = 0;
  int bad = 0;
  logic [7:0] va[$];
  logic [7:0] vb[$];

  always #5 clk = ~clk;

  // Multiplier behaviour: 0 exact, 1 fixed overrides, 2 truncated low 3 bits.
  function automatic logic [15:0] bench_mul(input int md, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (md)
      1: begin
        if (p == 16'd200) return 16'd100;
        if (p == 16'd16) return 16'd20;
        return p;
      end
      2: return p & 16'hFFF8;
      default: return p;
    endcase
  endfunction

  assign mul_o   = bench_mul(mode, mul_a, mul_b);
  assign mul_o16 = bench_mul(mode, mul_a16, mul_b16);

  mul8_dot_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_A(in_a), .IN_B(in_b), .IN_LAST(in_last), .MUL_A(mul_a), .MUL_B(mul_b),
    .MUL_O(mul_o), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_SUM(out_sum),
    .OUT_CNT(out_cnt), .OUT_OVF(out_ovf), .OUT_ERR(out_err)
  );

  mul8_dot_acc #(.ACC_W(ACC16_W), .CNT_W(CNT_W)) dut16 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready16),
    .IN_A(in_a), .IN_B(in_b), .IN_LAST(in_last), .MUL_A(mul_a16), .MUL_B(mul_b16),
    .MUL_O(mul_o16), .OUT_VALID(out_valid16), .OUT_READY(out_ready), .OUT_SUM(out_sum16),
    .OUT_CNT(out_cnt16), .OUT_OVF(out_ovf16), .OUT_ERR(out_err16)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Drive va/vb as one vector, check latency, result, hold behaviour and clear.
  task automatic run_vec(input string tag, input longint e_sum, input longint e_cnt,
                         input longint e_ovf, input longint e_sum16, input longint e_ovf16,
                         input longint e_err, input longint e_err16,
                         input bit gaps, input int hold, input bit pend);
    int n;
    n = va.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        in_last = 1'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      in_last = (i == n - 1);
      chk({tag, ".in_ready"}, in_ready, 1);
      step();
      chk({tag, ".mul_a"}, mul_a, va[i]);
      chk({tag, ".mul_b"}, mul_b, vb[i]);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk({tag, ".flush_valid"}, out_valid, 0);
    chk({tag, ".flush_ready"}, in_ready, 0);
    step();
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".sum"}, out_sum, e_sum);
    chk({tag, ".cnt"}, out_cnt, e_cnt);
    chk({tag, ".ovf"}, out_ovf, e_ovf);
    chk({tag, ".err"}, out_err, e_err);
    chk({tag, ".sum16"}, out_sum16, e_sum16);
    chk({tag, ".ovf16"}, out_ovf16, e_ovf16);
    chk({tag, ".err16"}, out_err16, e_err16);
    chk({tag, ".cnt16"}, out_cnt16, e_cnt);
    for (int h = 0; h < hold; h++) begin
      if (pend) begin
        in_valid = 1'b1;
        in_a = 8'd7;
        in_b = 8'd7;
        in_last = 1'b1;
      end
      step();
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_sum"}, out_sum, e_sum);
      chk({tag, ".hold_ready"}, in_ready, 0);
      chk({tag, ".hold_mul_a"}, mul_a, va[n-1]);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".clr_valid"}, out_valid, 0);
    chk({tag, ".clr_sum"}, out_sum, 0);
    chk({tag, ".clr_cnt"}, out_cnt, 0);
    chk({tag, ".clr_ready"}, in_ready, 1);
  endtask

  // Reference: plain sums over the vector, saturation applied to the totals.
  task automatic run_model(input string tag, input bit gaps, input int hold);
    longint raw, er, p, o, cnt;
    raw = 0;
    er = 0;
    for (int i = 0; i < va.size(); i++) begin
      p = longint'(va[i]) * longint'(vb[i]);
      o = longint'(bench_mul(mode, va[i], vb[i]));
      raw += o;
      er += (p > o) ? p - o : o - p;
    end
    cnt = (va.size() > 255) ? 255 : longint'(va.size());
`ifndef MUL8_DOT_ACC_ERR_MON_EN
    er = 0;
`endif
    run_vec(tag, sat(raw, ACC_W), cnt, (raw > sat(raw, ACC_W)) ? 1 : 0,
            sat(raw, ACC16_W), (raw > sat(raw, ACC16_W)) ? 1 : 0,
            sat(er, ACC_W), sat(er, ACC16_W), gaps, hold, 1'b0);
  endtask

  typedef struct {
    int n;
    logic [31:0] a;
    logic [31:0] b;
    int sum;
    int cnt;
    int ovf;
    int sum16;
    int ovf16;
  } vec_t;

  vec_t tbl[5];

  initial begin
    longint e_err;
    logic [31:0] wa, wb;

    tbl[0] = '{1, 32'h00000003, 32'h00000005, 15, 1, 0, 15, 0};
    tbl[1] = '{4, 32'hFFFFFFFF, 32'hFFFFFFFF, 260100, 4, 0, 65535, 1};
    tbl[2] = '{1, 32'h00000002, 32'h00000002, 4, 1, 0, 4, 0};
    tbl[3] = '{2, 32'h0000FF01, 32'h000001FF, 510, 2, 0, 510, 0};
    tbl[4] = '{3, 32'h00000000, 32'h00C80A0B, 0, 3, 0, 0, 0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_a = 8'd0;
    in_b = 8'd0;
    out_ready = 1'b0;
    mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.sum", out_sum, 0);

    // Table vectors; entry 1 then 2 exercises 16-bit saturation and its clearing.
    for (int t = 0; t < 5; t++) begin
      wa = tbl[t].a;
      wb = tbl[t].b;
      va.delete();
      vb.delete();
      for (int i = 0; i < tbl[t].n; i++) begin
        va.push_back(wa[8*i +: 8]);
        vb.push_back(wb[8*i +: 8]);
      end
      run_vec($sformatf("tbl%0d", t), tbl[t].sum, tbl[t].cnt, tbl[t].ovf,
              tbl[t].sum16, tbl[t].ovf16, 0, 0, 1'b0, (t == 1) ? 2 : 0, 1'b0);
    end

    // Reset mid-vector after two accepted pairs.
    in_valid = 1'b1;
    in_a = 8'd9;
    in_b = 8'd9;
    in_last = 1'b0;
    step();
    in_a = 8'd8;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", out_valid, 0);
    chk("mrst.sum", out_sum, 0);
    chk("mrst.cnt", out_cnt, 0);
    chk("mrst.in_ready", in_ready, 1);
    chk("mrst.mul_a", mul_a, 0);
    chk("mrst.mul_b", mul_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mrst.post_sum", out_sum, 0);
    chk("mrst.post_cnt", out_cnt, 0);
    va = '{8'd3};
    vb = '{8'd5};
    run_vec("mrst.next", 15, 1, 0, 15, 0, 0, 0, 1'b0, 0, 1'b0);

    // Backpressure with a pending (7,7) that must wait for the handshake.
    va = '{8'd10};
    vb = '{8'd3};
    run_vec("bp", 30, 1, 0, 30, 0, 0, 0, 1'b0, 5, 1'b1);
    va = '{8'd7};
    vb = '{8'd7};
    run_vec("bp.next", 49, 1, 0, 49, 0, 0, 0, 1'b0, 0, 1'b0);

    // Forced multiplier outputs for the error monitor.
    mode = 1;
    va = '{8'd20, 8'd4};
    vb = '{8'd10, 8'd4};
`ifdef MUL8_DOT_ACC_ERR_MON_EN
    e_err = 104;
`else
    e_err = 0;
`endif
    run_vec("errmon", 120, 2, 0, 120, 0, e_err, e_err, 1'b0, 0, 1'b0);

    // Randomized vectors against the reference model.
    for (int r = 0; r < 25; r++) begin
      mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      va.delete();
      vb.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
        va.push_back(8'($urandom));
        vb.push_back(8'($urandom));
      end
      run_model($sformatf("rnd%0d", r), 1'b1, int'($urandom_range(0, 3)));
    end

    // Long vector: 24-bit saturation and counter saturation.
    mode = 0;
    va.delete();
    vb.delete();
    for (int i = 0; i < 300; i++) begin
      va.push_back(8'd255);
      vb.push_back(8'd255);
    end
    run_model("long", 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul8_dot_acc.md
Name: mul8_dot_acc

Overview:
- Sequential dot-product accumulator placed directly downstream of the 8x8 approximate multipliers (A, B -> O[15:0]).
- Accepts operand pairs over a valid/ready stream and registers them onto MUL_A/MUL_B, which drive an external multiplier instance.
- Sums the returned MUL_O products over a LAST-terminated vector and presents the saturated sum and product count on an output handshake.
- Lets any library multiplier be evaluated in a streaming MAC context.

Parameters:
- ACC_W, 24, accumulator and OUT_SUM width; legal range 16..32.
- CNT_W, 8, product-counter and OUT_CNT width.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand pair valid.
- IN_READY  output  1  block can accept a pair.
- IN_A  input  8  operand A, unsigned.
- IN_B  input  8  operand B, unsigned.
- IN_LAST  input  1  marks the final pair of a vector.
- MUL_A  output  8  registered operand to the multiplier A input.
- MUL_B  output  8  registered operand to the multiplier B input.
- MUL_O  input  16  combinational product returned from the multiplier.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts the result.
- OUT_SUM  output  ACC_W  accumulated sum.
- OUT_CNT  output  CNT_W  number of products summed.
- OUT_OVF  output  1  sticky flag: accumulator saturated during this vector.
- OUT_ERR  output  ACC_W  accumulated absolute error; see Optional Feature.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N; assertion clears all state immediately.
- Reset values: all registers 0, OUT_VALID=0, state ACC, so IN_READY=1 after reset release. Reset mid-vector discards partial sums; no result is emitted.
- States:
  - ACC: IN_READY=1.
  - FLUSH: IN_READY=0; last pair is in the operand stage.
  - HOLD: IN_READY=0, OUT_VALID=1.
- Operand stage: on each accept (IN_VALID & IN_READY), IN_A/IN_B load MUL_A/MUL_B and a stage-valid bit S1V is set. When no accept occurs, S1V clears and MUL_A/MUL_B hold their values.
- Accumulate stage: on an edge with S1V=1:
  - ACC <= sat(ACC + MUL_O), using unsigned saturation to 2^ACC_W-1. OUT_OVF is set if saturation occurs.
  - CNT <= CNT+1, saturating at 2^CNT_W-1 (no flag).
- Transitions:
  - ACC -> FLUSH on an accept with IN_LAST=1.
  - FLUSH -> HOLD on the next edge, which performs the final accumulation.
  - HOLD -> ACC on OUT_VALID & OUT_READY; that edge clears ACC, CNT, OUT_OVF and OUT_ERR.
- Latency: a last pair accepted at edge k produces OUT_VALID=1 visible after edge k+1. Throughput is one pair per cycle within a vector.
- Per-vector overhead: two dead cycles before the next vector can be accepted (FLUSH, plus the HOLD cycle with handshake). IN_READY is combinational from state only.
- Output stability: OUT_SUM, OUT_CNT, OUT_OVF and OUT_ERR are driven directly from registers and are stable throughout HOLD. OUT_VALID is never withdrawn before the handshake.
- OUT_READY is ignored outside HOLD.
- IN_A, IN_B and IN_LAST are ignored when IN_VALID=0.
- A vector of length 1 (LAST on the first pair) is legal.
- MUL_O is sampled only on edges where S1V=1.

Optional Feature:
- Macro: MUL8_DOT_ACC_ERR_MON_EN.
- When defined:
  - An internal exact 8x8 product of MUL_A*MUL_B is computed.
  - Each S1V edge adds |exact - MUL_O| into an ERR register of ACC_W bits, with saturation.
  - ERR is presented on OUT_ERR and cleared with ACC.
- When undefined: no exact multiplier or ERR register is built, and OUT_ERR is tied to 0. Port list is identical in both builds.

Test Plan:
- Common bench setup: MUL_O is driven by the bench's exact model (MUL_A*MUL_B) unless stated otherwise.
- Reset: drive RST_N=0 mid-vector after 2 pairs, then release -> OUT_VALID=0, OUT_SUM=0, OUT_CNT=0, IN_READY=1, MUL_A=MUL_B=0.
- Single pair: A=3, B=5, LAST=1 -> OUT_VALID high the 2nd cycle after accept, OUT_SUM=15, OUT_CNT=1, OUT_OVF=0.
- Back-to-back vector: four pairs (255,255) on consecutive cycles, LAST on the 4th -> OUT_SUM=260100, OUT_CNT=4, IN_READY=0 until the handshake.
- Saturation: with ACC_W=16, two pairs (255,255) -> OUT_SUM=65535, OUT_OVF=1; the next vector (2,2) -> OUT_SUM=4, OUT_OVF=0.
- Backpressure: hold OUT_READY=0 for 5 cycles in HOLD, with IN_VALID=1 and a pending (7,7) -> OUT_VALID and OUT_SUM stable, no accept. After OUT_READY=1, (7,7) is accepted on the next cycle and the new OUT_SUM=49.
- Error monitor (macro defined): pair (20,10) with MUL_O forced to 100, then pair (4,4) with MUL_O forced to 20, LAST -> OUT_SUM=120, OUT_ERR=104. With the macro undefined, OUT_ERR=0.
